// File: rtl/spu_sequencer.sv
// spu_sequencer: drives the SPU register bus from a queued command stream, one access per T-cycle slot.
// Define SPU_SEQ_READBACK_EN to enable READ and POLL; otherwise opcodes 1 and 3 are rejected as illegal.
module spu_sequencer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ISSUE_PHASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tphase,
  input  logic [23:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        read,
  output logic        write,
  input  logic [7:0]  bus_out,
  input  logic        bus_oe,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        error
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  SLOT_PHASE = 8'(ISSUE_PHASE % 8);
  localparam logic [7:0]  ARM_PHASE  = 8'((ISSUE_PHASE + 7) % 8);
  localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] COUNT_ONE  = 1;
  localparam logic [1:0]  OP_WRITE   = 2'd0;
  localparam logic [1:0]  OP_READ    = 2'd1;
  localparam logic [1:0]  OP_WAIT    = 2'd2;
  localparam logic [1:0]  OP_POLL    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ARM,
    S_ACCESS,
    S_WAITING
`ifdef SPU_SEQ_READBACK_EN
    , S_CAPTURE
`endif
  } state_t;

  // Reserved command bits are dropped before the FIFO, so it only stores opcode + args.
  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          cmd_ready_reg;
  logic [17:0]   cmd_reg;
  logic          push, pop, fifo_empty;
  logic          unused_reserved;

  assign unused_reserved = ^cmd_data[21:16];
  assign push            = cmd_valid && cmd_ready_reg;
  assign fifo_empty      = (count_reg == '0);
  assign cmd_ready       = cmd_ready_reg;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_data[23:22], cmd_data[15:0]};
    if (pop)  cmd_reg <= fifo_mem[rd_ptr_reg];
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      cmd_ready_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      cmd_ready_reg <= (count_next != FULL_COUNT);
    end
  end

  logic [1:0]  op;
  logic [7:0]  arg_hi, arg_lo;
  logic        addr_ok, cmd_illegal;

  assign op      = cmd_reg[17:16];
  assign arg_hi  = cmd_reg[15:8];
  assign arg_lo  = cmd_reg[7:0];
  assign addr_ok = (arg_hi >= 8'h10) && (arg_hi <= 8'h3F);
`ifdef SPU_SEQ_READBACK_EN
  assign cmd_illegal = (op != OP_WAIT) && !addr_ok;
`else
  assign cmd_illegal = (op == OP_READ) || (op == OP_POLL) || ((op == OP_WRITE) && !addr_ok);
`endif

  state_t      state_reg, state_next;
  logic [15:0] wait_cnt_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_reg;
  logic        write_reg, error_reg;
  logic        arm, err_set, wait_load, wait_dec, take_next;
`ifdef SPU_SEQ_READBACK_EN
  logic        capture, poll_busy;
  logic [7:0]  cap_val;
  assign cap_val   = bus_oe ? bus_out : 8'hFF;
  assign poll_busy = (cap_val & arg_lo) != 8'h00;
`endif

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    arm        = 1'b0;
    err_set    = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    take_next  = 1'b0;
`ifdef SPU_SEQ_READBACK_EN
    capture    = 1'b0;
`endif
    case (state_reg)
      S_IDLE: take_next = 1'b1;
      S_DECODE: begin
        if (cmd_illegal) begin
          err_set   = 1'b1;
          take_next = 1'b1;
        end else if (op == OP_WAIT) begin
          if ({arg_hi, arg_lo} != 16'd0) begin
            wait_load  = 1'b1;
            state_next = S_WAITING;
          end else begin
            take_next = 1'b1;
          end
        end else begin
          state_next = S_ARM;
        end
      end
      // Strobes are registered, so they are loaded one clk ahead of the slot.
      S_ARM: begin
        if (tphase == ARM_PHASE) begin
          arm        = 1'b1;
          state_next = S_ACCESS;
        end
      end
`ifdef SPU_SEQ_READBACK_EN
      S_ACCESS: begin
        if (op == OP_WRITE) take_next = 1'b1;
        else                state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        if ((op == OP_POLL) && poll_busy) state_next = S_ARM;
        else                              take_next  = 1'b1;
      end
`else
      S_ACCESS: take_next = 1'b1;
`endif
      S_WAITING: begin
        if (tphase == SLOT_PHASE) begin
          wait_dec = 1'b1;
          if (wait_cnt_reg == 16'd1) take_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (take_next) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        state_next = S_DECODE;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      write_reg    <= 1'b0;
      error_reg    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      write_reg <= arm && (op == OP_WRITE);
      if (arm) begin
        addr_reg <= {8'hFF, arg_hi};
        if (op == OP_WRITE) data_reg <= arg_lo;
      end
      if (err_set) error_reg <= 1'b1;
      if (wait_load)     wait_cnt_reg <= {arg_hi, arg_lo};
      else if (wait_dec) wait_cnt_reg <= wait_cnt_reg - 16'd1;
    end
  end

`ifdef SPU_SEQ_READBACK_EN
  logic       read_reg, rd_valid_reg;
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      read_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      read_reg     <= arm && (op != OP_WRITE);
      rd_valid_reg <= capture && (op == OP_READ);
      if (capture && (op == OP_READ)) rd_data_reg <= cap_val;
    end
  end

  assign read     = read_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
`else
  logic unused_bus;
  assign unused_bus = ^{bus_out, bus_oe};
  assign read       = 1'b0;
  assign rd_valid   = 1'b0;
  assign rd_data    = 8'h00;
`endif

  assign addr  = addr_reg;
  assign data  = data_reg;
  assign write = write_reg;
  assign error = error_reg;
  // A READ stays busy through its rd_valid pulse.
  assign busy  = (state_reg != S_IDLE) || !fifo_empty || rd_valid;

endmodule
